// File: rtl/pwm_motor_pkg.sv
// Shared types, default constants and duty arithmetic for the multi-channel PWM motor driver.
package pwm_motor_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_BRAKE = 2'd1,
        ST_SWAP  = 2'd2
    } motor_state_t;

    localparam int DEF_NUM_CH    = 2;
    localparam int DEF_CNT_W     = 32;
    localparam int DEF_PERIOD    = 2000000;
    localparam int DEF_DUTY_INIT = 1000000;
    localparam int DEF_DUTY_MIN  = 0;
    localparam int DEF_DUTY_MAX  = 1800000;
    localparam int DEF_DUTY_STEP = 200000;
    localparam int DEF_DEADTIME  = 1000;

    // Wider than any supported CNT_W+1, so the sum/difference cannot wrap before clamping.
    localparam int SAT_W = 64;

    function automatic logic [SAT_W-1:0] duty_sat(
        input logic [SAT_W-1:0] cur,
        input logic [SAT_W-1:0] step,
        input logic [SAT_W-1:0] lo,
        input logic [SAT_W-1:0] hi,
        input logic             up,
        input logic             dn
    );
        logic [SAT_W-1:0] res;
        res = cur;
        if (up && !dn)
            res = (cur + step > hi) ? hi : cur + step;
        else if (dn && !up)
            res = (cur < lo + step) ? lo : cur - step;
        return res;
    endfunction

endpackage

// File: rtl/pwm_motor_chan.sv
// One motor channel: input conditioning, duty registers, reversal FSM and registered pwm/dir pins.
module pwm_motor_chan
    import pwm_motor_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int DUTY_INIT = DEF_DUTY_INIT,
    parameter int DUTY_MIN  = DEF_DUTY_MIN,
    parameter int DUTY_MAX  = DEF_DUTY_MAX,
    parameter int DUTY_STEP = DEF_DUTY_STEP,
    parameter int DEADTIME  = DEF_DEADTIME
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_wrap,
    input  logic             i_dir_toggle,
    input  logic             i_speed_up,
    input  logic             i_slow_down,
    output logic             o_pwm,
    output logic             o_dir_a,
    output logic             o_dir_b,
    output logic [CNT_W-1:0] o_duty
);

    localparam int DC_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

    logic [2:0]       w_req;
    logic [2:0]       r_s1, r_s2, r_s3, r_evt;
    logic             w_tog_evt, w_up_evt, w_dn_evt;
    logic [CNT_W-1:0] r_duty_tgt, r_duty_act;
    motor_state_t     r_state;
    logic [DC_W-1:0]  r_dead;
    logic             r_dir, r_pwm, r_dir_a, r_dir_b;

    assign w_req = {i_dir_toggle, i_speed_up, i_slow_down};

    // Two synchroniser stages, one history stage, then a registered rising-edge event.
    always_ff @(posedge i_clk) begin
        // NOTE: synchronous reset lives inside the clocked block; every state update uses <=.
        if (!i_rst_n) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_s3  <= '0;
            r_evt <= '0;
        end else begin
            r_s1  <= w_req;
            r_s2  <= r_s1;
            r_s3  <= r_s2;
            r_evt <= r_s2 & ~r_s3;
        end
    end

    assign {w_tog_evt, w_up_evt, w_dn_evt} = r_evt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_duty_tgt <= CNT_W'(DUTY_INIT);
            r_duty_act <= CNT_W'(DUTY_INIT);
        end else begin
            if (i_wrap)
                r_duty_act <= r_duty_tgt;
            r_duty_tgt <= CNT_W'(duty_sat(SAT_W'(r_duty_tgt), SAT_W'(DUTY_STEP),
                                          SAT_W'(DUTY_MIN), SAT_W'(DUTY_MAX),
                                          w_up_evt, w_dn_evt));
        end
    end

    // Outputs are registered alongside the state so the pins switch on the same edge as the FSM.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_RUN;
            r_dead  <= '0;
            r_dir   <= 1'b0;
            r_pwm   <= 1'b0;
            r_dir_a <= 1'b0;
            r_dir_b <= 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_tog_evt) begin
                        r_state <= ST_BRAKE;
                        r_dead  <= DC_W'(DEADTIME - 1);
                        r_pwm   <= 1'b0;
                        r_dir_a <= 1'b0;
                        r_dir_b <= 1'b0;
                    end else begin
                        r_pwm   <= i_en && (i_cnt < r_duty_act);
                        r_dir_a <= r_dir;
                        r_dir_b <= ~r_dir;
                    end
                end
                ST_BRAKE: begin
                    r_pwm   <= 1'b0;
                    r_dir_a <= 1'b0;
                    r_dir_b <= 1'b0;
                    if (r_dead == '0)
                        r_state <= ST_SWAP;
                    else
                        r_dead <= r_dead - DC_W'(1);
                end
                ST_SWAP: begin
                    r_state <= ST_RUN;
                    r_dir   <= ~r_dir;
                    r_pwm   <= 1'b0;
                    r_dir_a <= ~r_dir;
                    r_dir_b <= r_dir;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign o_pwm   = r_pwm;
    assign o_dir_a = r_dir_a;
    assign o_dir_b = r_dir_b;
    assign o_duty  = r_duty_act;

endmodule

// File: rtl/pwm_motor_ctrl.sv
// Multi-channel PWM motor driver top: shared period counter plus NUM_CH channel instances.
module pwm_motor_ctrl
    import pwm_motor_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int PERIOD    = DEF_PERIOD,
    parameter int DUTY_INIT = DEF_DUTY_INIT,
    parameter int DUTY_MIN  = DEF_DUTY_MIN,
    parameter int DUTY_MAX  = DEF_DUTY_MAX,
    parameter int DUTY_STEP = DEF_DUTY_STEP,
    parameter int DEADTIME  = DEF_DEADTIME
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NUM_CH-1:0]       dir_toggle,
    input  logic [NUM_CH-1:0]       speed_up,
    input  logic [NUM_CH-1:0]       slow_down,
    output logic [NUM_CH-1:0]       pwm,
    output logic [NUM_CH-1:0]       dir_a,
    output logic [NUM_CH-1:0]       dir_b,
    output logic [NUM_CH*CNT_W-1:0] duty_o
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = en && (r_cnt == CNT_W'(PERIOD - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || !en)
            r_cnt <= '0;
        else if (w_wrap)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CNT_W'(1);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        pwm_motor_chan #(
            .CNT_W     (CNT_W),
            .DUTY_INIT (DUTY_INIT),
            .DUTY_MIN  (DUTY_MIN),
            .DUTY_MAX  (DUTY_MAX),
            .DUTY_STEP (DUTY_STEP),
            .DEADTIME  (DEADTIME)
        ) u_chan (
            .i_clk        (clk),
            .i_rst_n      (rst_n),
            .i_en         (en),
            .i_cnt        (r_cnt),
            .i_wrap       (w_wrap),
            .i_dir_toggle (dir_toggle[g]),
            .i_speed_up   (speed_up[g]),
            .i_slow_down  (slow_down[g]),
            .o_pwm        (pwm[g]),
            .o_dir_a      (dir_a[g]),
            .o_dir_b      (dir_b[g]),
            .o_duty       (duty_o[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_pwm_motor_ctrl.sv
// Bench for pwm_motor_ctrl: directed scenarios plus random traffic against a timeline reference model.
module tb_pwm_motor_ctrl;

    localparam int NUM_CH    = 2;
    localparam int CNT_W     = 32;
    localparam int PERIOD    = 100;
    localparam int DUTY_INIT = 50;
    localparam int DUTY_MIN  = 0;
    localparam int DUTY_MAX  = 80;
    localparam int DUTY_STEP = 20;
    localparam int DEADTIME  = 10;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    en = 1'b0;
    logic [NUM_CH-1:0]       dir_toggle = '0;
    logic [NUM_CH-1:0]       speed_up = '0;
    logic [NUM_CH-1:0]       slow_down = '0;
    logic [NUM_CH-1:0]       pwm, dir_a, dir_b;
    logic [NUM_CH*CNT_W-1:0] duty_o;

    pwm_motor_ctrl #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .DUTY_INIT(DUTY_INIT),
        .DUTY_MIN(DUTY_MIN), .DUTY_MAX(DUTY_MAX), .DUTY_STEP(DUTY_STEP), .DEADTIME(DEADTIME)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dir_toggle(dir_toggle), .speed_up(speed_up),
        .slow_down(slow_down), .pwm(pwm), .dir_a(dir_a), .dir_b(dir_b), .duty_o(duty_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: each input is a history of samples; a channel reversal is a timeline
    // measured from the edge the toggle was accepted (brake, swap, then run again).
    bit              m_valid = 1'b0;
    int              m_cyc = 0;
    int              m_cnt;
    int              m_tgt [NUM_CH];
    int              m_act [NUM_CH];
    int              m_bs  [NUM_CH];
    bit              m_dir [NUM_CH];
    bit [3:0]        h_tog [NUM_CH];
    bit [3:0]        h_up  [NUM_CH];
    bit [3:0]        h_dn  [NUM_CH];
    logic [NUM_CH-1:0] m_pwm, m_dir_a, m_dir_b;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b1;
            m_cnt   = 0;
            m_pwm   = '0;
            m_dir_a = '0;
            m_dir_b = '1;
            for (int c = 0; c < NUM_CH; c++) begin
                m_tgt[c] = DUTY_INIT;
                m_act[c] = DUTY_INIT;
                m_dir[c] = 1'b0;
                m_bs[c]  = m_cyc - 100;
                h_tog[c] = '0;
                h_up[c]  = '0;
                h_dn[c]  = '0;
            end
        end else begin
            bit wrap;
            wrap = en && (m_cnt == PERIOD - 1);
            for (int c = 0; c < NUM_CH; c++) begin
                bit t_ev, u_ev, d_ev, old_run;
                int age;
                t_ev = h_tog[c][2] && !h_tog[c][3];
                u_ev = h_up[c][2]  && !h_up[c][3];
                d_ev = h_dn[c][2]  && !h_dn[c][3];
                old_run = (m_cyc - m_bs[c]) >= DEADTIME + 2;
                m_pwm[c] = en && old_run && !t_ev && (m_cnt < m_act[c]);
                if (old_run && t_ev)
                    m_bs[c] = m_cyc;
                age = m_cyc - m_bs[c];
                if (age == DEADTIME + 1)
                    m_dir[c] = !m_dir[c];
                m_dir_a[c] = (age >= DEADTIME + 1) ? m_dir[c]  : 1'b0;
                m_dir_b[c] = (age >= DEADTIME + 1) ? !m_dir[c] : 1'b0;
                if (wrap)
                    m_act[c] = m_tgt[c];
                if (u_ev && !d_ev)
                    m_tgt[c] = (m_tgt[c] + DUTY_STEP > DUTY_MAX) ? DUTY_MAX : m_tgt[c] + DUTY_STEP;
                else if (d_ev && !u_ev)
                    m_tgt[c] = (m_tgt[c] - DUTY_STEP < DUTY_MIN) ? DUTY_MIN : m_tgt[c] - DUTY_STEP;
                h_tog[c] = {h_tog[c][2:0], dir_toggle[c]};
                h_up[c]  = {h_up[c][2:0],  speed_up[c]};
                h_dn[c]  = {h_dn[c][2:0],  slow_down[c]};
            end
            m_cnt = en ? ((m_cnt == PERIOD - 1) ? 0 : m_cnt + 1) : 0;
        end
        m_cyc++;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("m_pwm",   64'(pwm),   64'(m_pwm));
            check("m_dir_a", 64'(dir_a), 64'(m_dir_a));
            check("m_dir_b", 64'(dir_b), 64'(m_dir_b));
            check("m_duty",  64'(duty_o), {32'(m_act[1]), 32'(m_act[0])});
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_up(input int c);
        speed_up[c] = 1'b1; cycles(2); speed_up[c] = 1'b0; cycles(3);
    endtask

    task automatic pulse_dn(input int c);
        slow_down[c] = 1'b1; cycles(2); slow_down[c] = 1'b0; cycles(3);
    endtask

    task automatic count2(input int n, output int h0, output int h1);
        h0 = 0;
        h1 = 0;
        repeat (n) begin
            @(negedge clk);
            h0 += int'(pwm[0]);
            h1 += int'(pwm[1]);
        end
    endtask

    initial begin
        int h0, h1;
        int upx [3];
        int dnx [4];
        upx = '{70, 80, 80};
        dnx = '{30, 10, 0, 0};

        cycles(3);
        check("rst_pwm",   64'(pwm),   64'(0));
        check("rst_dir_a", 64'(dir_a), 64'(0));
        check("rst_dir_b", 64'(dir_b), 64'(2'b11));
        check("rst_duty",  64'(duty_o), {32'd50, 32'd50});

        rst_n = 1'b1;
        en    = 1'b1;
        cycles(5);
        count2(300, h0, h1);
        check("hi_cnt0", 64'(h0), 64'(150));
        check("hi_cnt1", 64'(h1), 64'(150));
        check("run_dir_a", 64'(dir_a), 64'(0));
        check("run_dir_b", 64'(dir_b), 64'(2'b11));

        for (int i = 0; i < 3; i++) begin
            cycles(37);
            pulse_up(0);
            cycles(PERIOD + 10);
            check("up_duty0", 64'(duty_o[31:0]),  64'(upx[i]));
            check("up_duty1", 64'(duty_o[63:32]), 64'(50));
        end

        for (int i = 0; i < 4; i++) begin
            pulse_dn(1);
            cycles(PERIOD + 10);
            check("dn_duty1", 64'(duty_o[63:32]), 64'(dnx[i]));
        end
        count2(PERIOD, h0, h1);
        check("dn_zero_hi1", 64'(h1), 64'(0));
        check("sat_hi0",     64'(h0), 64'(80));

        rst_n = 1'b0; cycles(2); rst_n = 1'b1; cycles(2);

        speed_up[0] = 1'b1; slow_down[0] = 1'b1;
        cycles(50);
        check("both_hold", 64'(duty_o[31:0]), 64'(50));
        speed_up[0] = 1'b0; slow_down[0] = 1'b0;
        cycles(PERIOD + 10);
        check("both_after", 64'(duty_o[31:0]), 64'(50));

        dir_toggle[0] = 1'b1; cycles(2); dir_toggle[0] = 1'b0;
        cycles(1);
        check("tog_pre_b", 64'(dir_b[0]), 64'(1));
        for (int k = 0; k < DEADTIME + 1; k++) begin
            @(negedge clk);
            check("tog_brake", {61'd0, pwm[0], dir_a[0], dir_b[0]}, 64'(0));
            if (k == 1) dir_toggle[0] = 1'b1;
            if (k == 3) dir_toggle[0] = 1'b0;
        end
        @(negedge clk);
        check("tog_new_a", 64'(dir_a[0]), 64'(1));
        check("tog_new_b", 64'(dir_b[0]), 64'(0));
        cycles(20);
        check("tog_hold_a", 64'(dir_a[0]), 64'(1));
        count2(PERIOD, h0, h1);
        check("tog_resume_hi", 64'(h0), 64'(50));

        en = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("en_low_pwm", 64'(pwm), 64'(0));
        end
        en = 1'b1;
        @(negedge clk);
        check("en_first", 64'(pwm[0]), 64'(1));
        cycles(49);
        check("en_last_hi", 64'(pwm[0]), 64'(1));
        @(negedge clk);
        check("en_first_lo", 64'(pwm[0]), 64'(0));

        dir_toggle[1] = 1'b1; cycles(2); dir_toggle[1] = 1'b0;
        cycles(8);
        check("brk1_active", 64'(dir_b[1]), 64'(0));
        rst_n = 1'b0;
        @(negedge clk);
        check("brk1_rst_a", 64'(dir_a[1]), 64'(0));
        check("brk1_rst_b", 64'(dir_b[1]), 64'(1));
        check("brk1_rst_duty", 64'(duty_o), {32'd50, 32'd50});
        rst_n = 1'b1;

        for (int k = 0; k < 4000; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 39) == 0) dir_toggle[c] = ~dir_toggle[c];
                if ($urandom_range(0, 29) == 0) speed_up[c]   = ~speed_up[c];
                if ($urandom_range(0, 29) == 0) slow_down[c]  = ~slow_down[c];
            end
            if ($urandom_range(0, 299) == 0) en = ~en;
            rst_n = ($urandom_range(0, 1999) != 0);
            cycles(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_motor_ctrl.md
Name: pwm_motor_ctrl

Overview:
Multi-channel PWM motor/servo driver. Generalises the single-channel fixed-duty PWM generator to NUM_CH channels. Each channel has a run-time adjustable, saturating duty cycle driven by speed-up and slow-down pulses, and a glitch-free duty update at the period boundary. Each channel has an H-bridge direction pair with a dead-time brake on reversal. It sits between the board button/switch inputs and the motor-driver pins.

Parameters:
NUM_CH, 2, number of independent motor channels
CNT_W, 32, width of the period counter and duty values
PERIOD, 2000000, PWM period in clk cycles (20 ms at 100 MHz); counter runs 0..PERIOD-1
DUTY_INIT, 1000000, duty value after reset
DUTY_MIN, 0, lower saturation bound for duty
DUTY_MAX, 1800000, upper saturation bound for duty; must be <= PERIOD
DUTY_STEP, 200000, duty increment/decrement per accepted speed pulse
DEADTIME, 1000, cycles both direction outputs are held low during reversal; must be >= 1

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
en  in  1  global enable; low forces all pwm low and holds the counter at 0
dir_toggle  in  NUM_CH  per-channel asynchronous reverse request (button/switch level)
speed_up  in  NUM_CH  per-channel asynchronous duty-increase request
slow_down  in  NUM_CH  per-channel asynchronous duty-decrease request
pwm  out  NUM_CH  per-channel PWM output
dir_a  out  NUM_CH  per-channel H-bridge direction line A
dir_b  out  NUM_CH  per-channel H-bridge direction line B
duty_o  out  NUM_CH*CNT_W  per-channel active duty; channel i occupies bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset (rst_n low at posedge clk): counter=0; every channel: duty_tgt=duty_act=DUTY_INIT, pwm=0, dir_a=0, dir_b=1, state=RUN, sync/edge registers=0.
- Period counter is shared by all channels. When en=1 it increments by 1 each cycle and wraps from PERIOD-1 to 0; wrap is a 1-cycle strobe asserted on the cycle the counter is PERIOD-1. When en=0 the counter is held at 0.
- Input conditioning: each of dir_toggle/speed_up/slow_down passes through a 2-FF synchroniser, then a rising-edge detector. An accepted event reaches channel logic 3 cycles after the input's first sampled high. Held-high inputs produce exactly one event.
- Duty target update, per event cycle:
  - up only: duty_tgt = min(duty_tgt+DUTY_STEP, DUTY_MAX)
  - down only: duty_tgt = max(duty_tgt-DUTY_STEP, DUTY_MIN)
  - up and down in the same cycle: no change
- Arithmetic is performed at CNT_W+1 bits so neither overflow nor underflow can occur before clamping.
- duty_act loads duty_tgt only on the wrap strobe, so the PWM waveform never glitches mid-period. duty_o reflects duty_act.
- PWM output is registered with 1-cycle latency: pwm = en && (state==RUN) && (counter < duty_act).
  - duty_act=0 gives constant low.
  - duty_act=PERIOD gives constant high.
- Direction FSM per channel:
  - RUN: outputs normal. A dir_toggle event moves to BRAKE and loads the dead-time counter with DEADTIME-1.
  - BRAKE: pwm=0, dir_a=0, dir_b=0. The counter decrements each cycle; at 0 the FSM moves to SWAP.
  - SWAP: exactly 1 cycle; the stored direction inverts. Then return to RUN with dir_a/dir_b driven to the new direction.
  - dir_toggle events arriving in BRAKE or SWAP are dropped.
  - Speed events are accepted in every state.
- en=0 does not freeze the FSM or the duty registers; only pwm and the counter are affected.
- rst_n asserted mid-BRAKE returns to RUN with the reset direction (dir_a=0, dir_b=1) on the next cycle.

Decomposition:
- Package pwm_motor_pkg holds:
  - the state enum (RUN, BRAKE, SWAP)
  - default parameter constants
  - a duty saturating-add/sub function
- Natural sub-module: pwm_motor_chan holds one channel's sync/edge logic, duty registers, FSM and pwm/dir outputs. It takes counter and wrap from the top and is instantiated NUM_CH times in a generate loop. The top level holds only the shared counter and port packing.

Test Plan:
(Bench params: NUM_CH=2, PERIOD=100, DUTY_INIT=50, DUTY_STEP=20, DUTY_MIN=0, DUTY_MAX=80, DEADTIME=10.)
- Reset then en=1 for 300 cycles -> each pwm high exactly 50 of every 100 cycles; dir_a=0, dir_b=1; duty_o=50 on both channels.
- Pulse speed_up[0] 3 times (separate pulses) mid-period -> duty_o[0] goes 70, then 80, then stays 80 (saturated); each change is visible only after the next wrap; channel 1 remains 50.
- Pulse slow_down[1] 4 times -> duty 30, 10, 0, 0; pwm[1] constant low once 0 is applied.
- Drive speed_up[0] and slow_down[0] high in the same cycle -> duty unchanged at 50; hold both high for 50 cycles -> still 50.
- Pulse dir_toggle[0] -> 3 cycles later pwm[0]=0, dir_a[0]=dir_b[0]=0 for 10 cycles, then 1 SWAP cycle, then dir_a[0]=1, dir_b[0]=0 with pwm resuming; a second toggle during BRAKE is ignored.
- Drop en for 30 cycles -> pwm=0 and counter=0 while low; on re-enable, the period restarts from 0. Assert rst_n=0 during BRAKE -> next cycle state=RUN, dir_a=0, dir_b=1, duty=50.
